// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings, PC select codes, defaults.
package inst_fetch_unit_pkg;

    localparam int unsigned INST_W       = 32;
    localparam int unsigned MEM_LAT_MAX  = 3;
    localparam int unsigned CNT_W        = $clog2(MEM_LAT_MAX);
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
    localparam int unsigned PC_INC_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEL_HOLD  = 2'd0,
        PC_SEL_INC   = 2'd1,
        PC_SEL_REDIR = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction BRAM port plus the fetched-word handshake towards the decoder.
interface inst_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    import inst_fetch_unit_pkg::*;

    logic                imem_en;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INST_W-1:0]   imem_rdata;
    logic [INST_W-1:0]   inst;
    logic [ADDR_W-1:0]   inst_pc;
    logic                inst_valid;
    logic                inst_ready;

    // master = fetch unit, slave = BRAM + consumer side
    modport master (
        output imem_en, imem_addr, inst, inst_pc, inst_valid,
        input  imem_rdata, inst_ready
    );

    modport slave (
        input  imem_en, imem_addr, inst, inst_pc, inst_valid,
        output imem_rdata, inst_ready
    );

endinterface

// File: rtl/inst_fetch_unit_pc_next.sv
// Next-PC selection: hold, sequential increment (wraps mod 2^ADDR_W) or word-aligned redirect.
module inst_fetch_unit_pc_next
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned PC_INC = PC_INC_DEF
) (
    input  pc_sel_e             sel_i,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    output logic [ADDR_W-1:0]   next_pc_c_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    always_comb begin
        next_pc_c_o = pc_i;
        case (sel_i)
            PC_SEL_INC:   next_pc_c_o = pc_i + ADDR_W'(PC_INC);
            PC_SEL_REDIR: next_pc_c_o = redirect_pc_i & ALIGN_MASK;
            default:      next_pc_c_o = pc_i;
        endcase
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues one BRAM read per instruction, absorbs read latency
// and holds the fetched word for the decoder until a stepped hand-off or a redirect.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEF),
    parameter int unsigned       PC_INC   = PC_INC_DEF,
    parameter int unsigned       MEM_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    inst_fetch_unit_if.master   bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    fetch_state_e        state_q, state_d;
    pc_sel_e             pc_sel;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic                valid_q, valid_d;
    logic                imem_en_q, imem_en_d;
    logic                handoff;

    assign handoff = valid_q & bus.inst_ready & step;

    inst_fetch_unit_pc_next #(
        .ADDR_W (ADDR_W),
        .PC_INC (PC_INC)
    ) u_pc_next (
        .sel_i         (pc_sel),
        .pc_i          (pc_q),
        .redirect_pc_i (redirect_pc),
        .next_pc_c_o   (pc_d)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; redirect overrides every other transition
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = ST_REQ;
        end else begin
            case (state_q)
                ST_IDLE: if (step) state_d = ST_REQ;
                ST_REQ:  state_d = ST_WAIT;
                ST_WAIT: if (cnt_q == '0) state_d = ST_HOLD;
                ST_HOLD: if (handoff) state_d = ST_REQ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values; a redirect drops any in-flight read instead of capturing it
    always_comb begin
        pc_sel    = PC_SEL_HOLD;
        cnt_d     = cnt_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        if (redirect) begin
            pc_sel  = PC_SEL_REDIR;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_REQ: cnt_d = CNT_LOAD;
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        inst_d    = bus.imem_rdata;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (handoff) begin
                        pc_sel  = PC_SEL_INC;
                        valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        imem_en_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= PC_RESET;
            cnt_q     <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            imem_en_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            imem_en_q <= imem_en_d;
        end
    end

    assign bus.imem_en    = imem_en_q;
    assign bus.imem_addr  = pc_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = valid_q;

endmodule
